// File: rtl/spi_shift_master.sv
`default_nettype none
// ============================================================================
// spi_shift_master : SPI mode-0 master shifting one DATA_W-bit frame, with bit
//                    timing paced by an upstream divided clock.
// Revision 1.0
// ============================================================================
module spi_shift_master #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              div_clk_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic              abort_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              cs_n_o
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                div_q;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                cs_n_q, cs_n_d;
    logic                tx_ready_q, tx_ready_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                w_rise;
    logic                w_fall;

    // Bit that goes on the wire next, and the register after one bit has left
    function automatic logic lead_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] w,
                                                    input logic              b);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    assign w_rise = div_clk_i & ~div_q;
    assign w_fall = ~div_clk_i & div_q;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            div_q      <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            cnt_q      <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_clk_i;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            cnt_q      <= cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        cnt_d      = cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid_i && tx_ready_q) begin
                    state_d    = SETUP;
                    tx_sr_d    = tx_data_i;
                    cnt_d      = '0;
                    mosi_d     = lead_bit(tx_data_i);
                    sclk_d     = 1'b0;
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    tx_ready_d = 1'b0;
                end
            end
            SETUP: begin
                // A rise here would sample before the slave saw a full setup time
                if (w_fall) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (w_rise) begin
                    sclk_d  = 1'b1;
                    rx_sr_d = rx_insert(rx_sr_q, miso_i);
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (w_fall) begin
                    sclk_d = 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        state_d    = DONE;
                        cs_n_d     = 1'b1;
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        tx_sr_d = tx_advance(tx_sr_q);
                        mosi_d  = lead_bit(tx_sr_d);
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                cs_n_d     = 1'b1;
                sclk_d     = 1'b0;
                busy_d     = 1'b0;
                tx_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort drops the frame without publishing any partial receive data
        if (abort_i && (state_q != IDLE)) begin
            state_d    = IDLE;
            cs_n_d     = 1'b1;
            sclk_d     = 1'b0;
            busy_d     = 1'b0;
            tx_ready_d = 1'b1;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
        end
    end

    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;
    assign sclk_o     = sclk_q;
    assign mosi_o     = mosi_q;
    assign cs_n_o     = cs_n_q;

endmodule
`default_nettype wire
